ps2_key_decoder: RTL and testbench

- Upstream stage of the game processor. Receives raw PS/2 keyboard frames on ps2_clk/ps2_dat and turns scan-code sequences into key events.
- Outputs keycode, key_make and key_ext, which wire straight into the processor's keycode/key_make/key_ext inputs, plus a one-cycle key_valid strobe.
- Handles synchronisation, glitch filtering, 11-bit frame capture, parity/stop checking, the inter-bit watchdog, and E0/F0 prefix decoding.

---
 rtl/ps2_key_decoder_if.sv | 18 +
 rtl/ps2_key_decoder.sv | 178 +++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_key_decoder_if.sv
// Key-event bus from the PS/2 decoder to the game processor.
interface ps2_key_decoder_if;
  logic [7:0] keycode;
  logic       key_make;
  logic       key_ext;
  logic       key_valid;
  logic       frame_err;

  modport master (
    output keycode, key_make, key_ext,
    output key_valid, frame_err
  );

  modport slave (
    input keycode, key_make, key_ext,
    input key_valid, frame_err
  );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 frame receiver and E0/F0 scan-code decoder.
// Optional TYPEMATIC_FILTER_EN drops repeated makes of a held key.
module ps2_key_decoder #(
  parameter int DEB_CYCLES     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_dat,
  ps2_key_decoder_if.master key
);

  localparam int DBW = $clog2(DEB_CYCLES + 1);
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DBW-1:0] DEB_LAST = DBW'(DEB_CYCLES - 1);
  localparam logic [WDW-1:0] WD_LAST  = WDW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;
  typedef enum logic [1:0] {K_KEY, K_EXT, K_BRK, K_DROP} kind_t;

  logic           c_s1, c_s2, d_s1, d_s2;
  logic           filt;
  logic [DBW-1:0] deb;
  logic           fe;
  state_t         state, state_nx;
  logic [3:0]     bitcnt;
  logic [9:0]     sr;
  logic [WDW-1:0] wd;
  logic           tmo, good, err;
  logic           ext_pend, brk_pend;
  kind_t          kind;
  logic           ev, make, suppress, emit;

  // Idle PS/2 lines float high, so the synchronisers reset to 1
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_s1 <= 1'b1;
      c_s2 <= 1'b1;
      d_s1 <= 1'b1;
      d_s2 <= 1'b1;
    end else begin
      c_s1 <= ps2_clk;
      c_s2 <= c_s1;
      d_s1 <= ps2_dat;
      d_s2 <= d_s1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt <= 1'b1;
      deb  <= '0;
    end else if (c_s2 == filt) begin
      deb  <= '0;
    end else if (deb == DEB_LAST) begin
      filt <= c_s2;
      deb  <= '0;
    end else begin
      deb  <= deb + 1'b1;
    end
  end

  assign fe = filt & ~c_s2 & (deb == DEB_LAST);

  assign tmo = (state == SHIFT) & ~fe & (wd == WD_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (fe && !d_s2) state_nx = SHIFT;
      SHIFT: begin
        if (fe && bitcnt == 4'd10) state_nx = CHECK;
        else if (tmo)              state_nx = IDLE;
      end
      CHECK: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bitcnt <= '0;
      sr     <= '0;
      wd     <= '0;
    end else begin
      wd <= (fe || state != SHIFT) ? '0 : wd + 1'b1;
      if (fe && state == IDLE && !d_s2) begin
        bitcnt <= 4'd1;
      end else if (fe && state == SHIFT) begin
        sr     <= {d_s2, sr[9:1]};
        bitcnt <= bitcnt + 4'd1;
      end
    end
  end

  // After ten shifts: sr[7:0] data, sr[8] parity, sr[9] stop
  assign good = (state == CHECK) & (^sr[8:0]) & sr[9];
  assign err  = ((state == CHECK) & ~good) | tmo;

  always_comb begin
    kind = K_KEY;
    unique case (1'b1)
      (sr[7:0] == 8'hE0): kind = K_EXT;
      (sr[7:0] == 8'hF0): kind = K_BRK;
      (sr[7:0] inside {8'h00, 8'hAA, 8'hEE,
                       8'hFA, 8'hFE, 8'hFF}):
        kind = K_DROP;
      default: kind = K_KEY;
    endcase
  end

  assign ev   = good & (kind == K_KEY);
  assign make = ~brk_pend;
  assign emit = ev & ~suppress;

`ifdef TYPEMATIC_FILTER_EN
  logic       held_v;
  logic [8:0] held;

  assign suppress = make & held_v & (held == {ext_pend, sr[7:0]});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      held_v <= 1'b0;
      held   <= '0;
    end else if (ev) begin
      if (make) begin
        held_v <= 1'b1;
        held   <= {ext_pend, sr[7:0]};
      end else if (held == {ext_pend, sr[7:0]}) begin
        held_v <= 1'b0;
      end
    end
  end
`else
  assign suppress = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key.keycode   <= '0;
      key.key_make  <= 1'b0;
      key.key_ext   <= 1'b0;
      key.key_valid <= 1'b0;
      key.frame_err <= 1'b0;
      ext_pend      <= 1'b0;
      brk_pend      <= 1'b0;
    end else begin
      key.key_valid <= emit;
      key.frame_err <= err;
      if (emit) begin
        key.keycode  <= sr[7:0];
        key.key_make <= make;
        key.key_ext  <= ext_pend;
      end
      if (err) begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end else if (good) begin
        unique case (kind)
          K_EXT: ext_pend <= 1'b1;
          K_BRK: brk_pend <= 1'b1;
          default: begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: directed frames plus
// random scan-code streams against a queue-based event model.
module tb_ps2_key_decoder;

  localparam int DEB = 8;
  localparam int TMO = 400;
  localparam int H   = 25;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_dat = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ps2_key_decoder_if kif ();

  ps2_key_decoder #(
    .DEB_CYCLES(DEB),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ps2_clk(ps2_clk),
    .ps2_dat(ps2_dat),
    .key(kif)
  );

  typedef struct packed {
    logic       err;
    logic [7:0] code;
    logic       make;
    logic       ext;
  } ev_t;

  ev_t q[$];
  int  total = 0;
  int  passes = 0;
  int  fails = 0;
  int  kv_n = 0;
  int  err_n = 0;
  int  stop_cyc = 0;
  bit  lat_arm = 0;

  logic [7:0] x_code = 8'h00;
  logic       x_make = 1'b0;
  logic       x_ext  = 1'b0;
  logic       m_ext  = 1'b0;
  logic       m_brk  = 1'b0;
`ifdef TYPEMATIC_FILTER_EN
  logic       m_held_v = 1'b0;
  logic [8:0] m_held = '0;
`endif

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else begin
      fails++;
      if (fails <= 30)
        $display("FAIL %s: got %0h expected %0h @cyc %0d",
                 name, act, exp, cyc);
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic mk;
    logic sup;
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else if (b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF}) begin
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else begin
      mk  = ~m_brk;
      sup = 1'b0;
`ifdef TYPEMATIC_FILTER_EN
      if (mk && m_held_v && m_held == {m_ext, b}) sup = 1'b1;
      if (mk) begin
        m_held_v = 1'b1;
        m_held   = {m_ext, b};
      end else if (m_held == {m_ext, b}) m_held_v = 1'b0;
`endif
      if (!sup) q.push_back('{1'b0, b, mk, m_ext});
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic model_err();
    q.push_back('{1'b1, 8'h00, 1'b0, 1'b0});
    m_ext = 1'b0;
    m_brk = 1'b0;
  endtask

  task automatic model_reset();
    q.delete();
    m_ext  = 1'b0;
    m_brk  = 1'b0;
    x_code = 8'h00;
    x_make = 1'b0;
    x_ext  = 1'b0;
`ifdef TYPEMATIC_FILTER_EN
    m_held_v = 1'b0;
`endif
  endtask

  // bits[0] goes first on the wire
  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      ps2_dat = bits[i];
      repeat (H) @(posedge clk);
      #1;
      ps2_clk = 1'b0;
      if (i == 10) stop_cyc = cyc;
      repeat (H) @(posedge clk);
      #1;
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b,
                            input bit bad_par,
                            input bit bad_stop);
    logic par;
    par = ~(^b) ^ bad_par;
    if (bad_par || bad_stop) model_err();
    else model_byte(b);
    send_bits({~bad_stop, par, b, 1'b0}, 11);
    repeat (4) @(posedge clk);
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (!reset) begin
      chk("reset outputs",
          {kif.keycode, kif.key_make, kif.key_ext,
           kif.key_valid, kif.frame_err}, 32'h0);
    end else begin
      if (kif.key_valid) kv_n++;
      if (kif.frame_err) err_n++;
      if (kif.key_valid || kif.frame_err) begin
        if (q.size() == 0) begin
          chk("unexpected pulse",
              {kif.key_valid, kif.frame_err}, 32'h0);
        end else begin
          e = q.pop_front();
          chk("pulse kind", {kif.key_valid, kif.frame_err},
              e.err ? 32'h1 : 32'h2);
          if (!e.err) begin
            x_code = e.code;
            x_make = e.make;
            x_ext  = e.ext;
            if (lat_arm) chk("latency", cyc - stop_cyc, DEB + 3);
          end
          lat_arm = 0;
        end
      end
      chk("held outputs",
          {kif.keycode, kif.key_make, kif.key_ext},
          {x_code, x_make, x_ext});
    end
  end

  initial begin
    #3000000;
    $display("FAIL global timeout at cyc %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int n0;
    int e0;
    logic [7:0] b;
    logic [7:0] drop [6];
    drop = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};

    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    repeat (20) @(posedge clk);

    // Single make with exact latency
    lat_arm = 1;
    n0 = kv_n;
    send_frame(8'h1C, 0, 0);
    chk("1C pulses", kv_n - n0, 1);
    chk("1C code", kif.keycode, 8'h1C);
    chk("1C make", kif.key_make, 1);
    chk("1C ext", kif.key_ext, 0);

    // Extended break
    n0 = kv_n;
    send_frame(8'hE0, 0, 0);
    send_frame(8'hF0, 0, 0);
    chk("E0F0 no pulse", kv_n - n0, 0);
    send_frame(8'h75, 0, 0);
    chk("E0F075 pulses", kv_n - n0, 1);
    chk("75 code", kif.keycode, 8'h75);
    chk("75 make", kif.key_make, 0);
    chk("75 ext", kif.key_ext, 1);

    // Parity error clears a pending break
    n0 = kv_n;
    e0 = err_n;
    send_frame(8'hF0, 0, 0);
    send_frame(8'h1C, 1, 0);
    chk("parity err", err_n - e0, 1);
    chk("parity no kv", kv_n - n0, 0);
    chk("parity hold code", kif.keycode, 8'h75);
    send_frame(8'h1C, 0, 0);
    chk("after err make", kif.key_make, 1);

    // Truncated frame then watchdog abort
    e0 = err_n;
    model_err();
    send_bits(11'b000_0001_1010, 5);
    repeat (TMO + 60) @(posedge clk);
    chk("timeout err", err_n - e0, 1);
    send_frame(8'h29, 0, 0);
    chk("29 code", kif.keycode, 8'h29);
    chk("29 make", kif.key_make, 1);

    // Reset mid-frame
    send_bits(11'b000_0011_0100, 5);
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    #1;
    chk("async reset",
        {kif.keycode, kif.key_make, kif.key_ext,
         kif.key_valid, kif.frame_err}, 32'h0);
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    repeat (10) @(posedge clk);
    send_frame(8'h1C, 0, 0);
    chk("post reset code", kif.keycode, 8'h1C);

    // Short glitch on ps2_clk
    n0 = kv_n;
    e0 = err_n;
    @(posedge clk); #1 ps2_clk = 1'b0;
    repeat (3) @(posedge clk);
    #1 ps2_clk = 1'b1;
    repeat (TMO + 20) @(posedge clk);
    chk("glitch pulses", (kv_n - n0) + (err_n - e0), 0);

    // Typematic repeats
    send_frame(8'hF0, 0, 0);
    send_frame(8'h1C, 0, 0);
    n0 = kv_n;
    send_frame(8'h1C, 0, 0);
    send_frame(8'h1C, 0, 0);
    send_frame(8'h1C, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h1C, 0, 0);
`ifdef TYPEMATIC_FILTER_EN
    chk("typematic pulses", kv_n - n0, 2);
`else
    chk("typematic pulses", kv_n - n0, 4);
`endif
    chk("typematic last make", kif.key_make, 0);

    // Random scan-code stream
    for (int i = 0; i < 40; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 20) b = 8'hE0;
      else if (r < 40) b = 8'hF0;
      else if (r < 48) b = drop[$urandom_range(0, 5)];
      else if (r < 60) b = 8'h1C;
      else b = 8'($urandom_range(0, 255));
      send_frame(b, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 19) == 0);
    end

    repeat (20) @(posedge clk);
    chk("queue drained", q.size(), 0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
